interval_timer: RTL and testbench

Parametrised, run-time programmable interval timer for game timing and display pacing, generalising the fixed 1 ms / 100 ms tick chain. A prescaler divides `clk` into base ticks, and a period counter divides base ticks into timeout pulses. It supports periodic and one-shot modes, pause via `enable`, synchronous restart, and period reprogramming while running.

---
 rtl/interval_timer.sv | 183 ++++++++++++++++++
 tb/tb_interval_timer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// interval_timer
//
// Run-time programmable interval timer. A prescaler divides clk into base
// ticks, and a period counter divides base ticks into timeout pulses.
// Supports periodic and one-shot modes, pause via enable, synchronous
// restart and live reprogramming of the period.
//
// Parameters:
//   PRESCALE   clk cycles per base tick (>= 2)
//   PRESCALE_W prescaler width, must hold PRESCALE-1
//   PERIOD_W   width of period and count
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   enable       in   1 = count, 0 = pause (all counters hold)
//   restart      in   synchronous clear back to IDLE, highest priority
//   mode         in   0 = periodic, 1 = one-shot
//   period       in   base ticks per interval, 0 = disabled
//   base_tick    out  one-cycle pulse per base tick
//   timeout      out  one-cycle pulse at the end of each interval
//   count        out  base ticks elapsed in the current interval
//   running      out  timer in RUN with enable high (registered)
//   done         out  one-shot interval complete (level)
//
// Optional feature, enabled by defining INTERVAL_TIMER_STICKY_EN:
//   flag_clr     in   clears timeout_flag
//   timeout_flag out  sticky copy of timeout; a set wins over a clear
//                     and restart leaves it untouched

module interval_timer #(
  parameter int PRESCALE   = 50000,
  parameter int PRESCALE_W = 16,
  parameter int PERIOD_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                restart,
  input  logic                mode,
  input  logic [PERIOD_W-1:0] period,
`ifdef INTERVAL_TIMER_STICKY_EN
  input  logic                flag_clr,
  output logic                timeout_flag,
`endif
  output logic                base_tick,
  output logic                timeout,
  output logic [PERIOD_W-1:0] count,
  output logic                running,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateType;

  localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(PRESCALE - 1);
  localparam logic [PRESCALE_W-1:0] PRESCALE_ONE = PRESCALE_W'(1);
  localparam logic [PERIOD_W-1:0]   PERIOD_ONE   = PERIOD_W'(1);

  stateType              state;
  logic [PRESCALE_W-1:0] prescaleCnt;
  logic [PERIOD_W-1:0]   lastCount;
  logic                  prescaleWrap;
  logic                  intervalEnd;

  // lastCount underflows when period is 0, but that case is handled
  // before intervalEnd is ever consulted.
  assign lastCount    = period - PERIOD_ONE;
  assign prescaleWrap = (prescaleCnt == PRESCALE_MAX);
  // Using >= rather than == means shrinking period below the current count
  // ends the interval at the next base tick instead of wrapping around.
  assign intervalEnd  = (count >= lastCount);

  // Main timer FSM. Pulses default low every edge and are only raised on
  // the prescaler wrap in RUN. restart is checked first so it suppresses
  // any pulse due on the same edge; period==0 is checked before the enable
  // test so a disabled period drops back to IDLE even while paused.
  // running is registered from the next state, so it lags enable by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      prescaleCnt <= '0;
      count       <= '0;
      base_tick   <= 1'b0;
      timeout     <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      base_tick <= 1'b0;
      timeout   <= 1'b0;
      if (restart) begin
        state       <= IDLE;
        prescaleCnt <= '0;
        count       <= '0;
        running     <= 1'b0;
        done        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            prescaleCnt <= '0;
            count       <= '0;
            done        <= 1'b0;
            if (enable && (period != '0)) begin
              state   <= RUN;
              running <= 1'b1;
            end else begin
              running <= 1'b0;
            end
          end

          RUN: begin
            if (period == '0) begin
              state       <= IDLE;
              prescaleCnt <= '0;
              count       <= '0;
              running     <= 1'b0;
            end else if (!enable) begin
              running <= 1'b0;
            end else begin
              running <= 1'b1;
              if (prescaleWrap) begin
                prescaleCnt <= '0;
                base_tick   <= 1'b1;
                if (intervalEnd) begin
                  count   <= '0;
                  timeout <= 1'b1;
                  if (mode) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    running <= 1'b0;
                  end
                end else begin
                  count <= count + PERIOD_ONE;
                end
              end else begin
                prescaleCnt <= prescaleCnt + PRESCALE_ONE;
              end
            end
          end

          DONE: begin
            prescaleCnt <= '0;
            count       <= '0;
            running     <= 1'b0;
            done        <= 1'b1;
          end

          default: begin
            state       <= IDLE;
            prescaleCnt <= '0;
            count       <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef INTERVAL_TIMER_STICKY_EN
  logic timeoutNow;

  // Same condition under which the FSM raises timeout on this edge.
  assign timeoutNow = (state == RUN) && !restart && (period != '0) &&
                      enable && prescaleWrap && intervalEnd;

  // Sticky timeout flag. Setting takes priority over flag_clr so a timeout
  // arriving on the clearing edge is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_flag <= 1'b0;
    end else if (timeoutNow) begin
      timeout_flag <= 1'b1;
    end else if (flag_clr) begin
      timeout_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer
//
// Self-checking bench for interval_timer with PRESCALE=4, PERIOD_W=4.
// Expected timeout cycles are pushed to a queue when each scenario is
// started; a monitor pops and compares them whenever timeout is seen.
// Define INTERVAL_TIMER_STICKY_EN to also exercise the sticky flag.

module tb_interval_timer;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       restart;
  logic       mode;
  logic [3:0] period;
  logic       baseTick;
  logic       timeout;
  logic [3:0] count;
  logic       running;
  logic       done;
`ifdef INTERVAL_TIMER_STICKY_EN
  logic       flagClr;
  logic       timeoutFlag;
`endif

  int cycle = 0;
  int checkCount = 0;
  int passCount = 0;
  int expQ[$];
  int tStart;
  int tNext;

  interval_timer #(
    .PRESCALE(PRESCALE),
    .PRESCALE_W(3),
    .PERIOD_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .restart(restart),
    .mode(mode),
    .period(period),
`ifdef INTERVAL_TIMER_STICKY_EN
    .flag_clr(flagClr),
    .timeout_flag(timeoutFlag),
`endif
    .base_tick(baseTick),
    .timeout(timeout),
    .count(count),
    .running(running),
    .done(done)
  );

  // 10-unit clock; edge index counted on every rising edge.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] per, input logic md);
    enable = en;
    period = per;
    mode   = md;
  endtask

  task automatic waitUntil(input int target);
    while (cycle < target) @(negedge clk);
  endtask

  // Pulse restart with enable low so the timer parks in IDLE, then confirm
  // the cleared state and that every predicted timeout has been seen.
  task automatic endScenario(input string name);
    restart = 1'b1;
    enable  = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    checkOutput({name, "_restartCount"}, count, 0);
    checkOutput({name, "_restartDone"}, done, 0);
    checkOutput({name, "_restartRunning"}, running, 0);
    checkOutput({name, "_missedTimeouts"}, expQ.size(), 0);
    expQ.delete();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every timeout must match the next predicted cycle
  // and coincide with a base tick.
  always @(negedge clk) begin
    if (timeout) begin
      checkOutput("timeoutWithTick", baseTick, 1);
      if (expQ.size() == 0) begin
        checkOutput("spuriousTimeout", cycle, -1);
      end else begin
        checkOutput("timeoutCycle", cycle, expQ.pop_front());
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    restart = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0);
`ifdef INTERVAL_TIMER_STICKY_EN
    flagClr = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstBaseTick", baseTick, 0);
    checkOutput("rstTimeout", timeout, 0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstRunning", running, 0);
    checkOutput("rstDone", done, 0);
`ifdef INTERVAL_TIMER_STICKY_EN
    checkOutput("rstFlag", timeoutFlag, 0);
`endif

    // Periodic, period 3, enabled from reset release
    rst = 1'b1;
    applyStimulus(1'b1, 4'd3, 1'b0);
    tStart = cycle + 1;
    expQ.push_back(tStart + 12);
    expQ.push_back(tStart + 24);
    for (int k = 0; k <= 24; k++) begin
      waitUntil(tStart + k);
      checkOutput("perBaseTick", baseTick, (k > 0 && (k % 4) == 0) ? 1 : 0);
      checkOutput("perCount", count, (k / 4) % 3);
      checkOutput("perRunning", running, 1);
    end
    endScenario("periodic");

    // One-shot, period 2
    applyStimulus(1'b1, 4'd2, 1'b1);
    tStart = cycle + 1;
    expQ.push_back(tStart + 8);
    waitUntil(tStart + 7);
    checkOutput("osDoneEarly", done, 0);
    checkOutput("osRunning", running, 1);
    waitUntil(tStart + 8);
    checkOutput("osDone", done, 1);
    checkOutput("osRunningOff", running, 0);
    checkOutput("osCount", count, 0);
    for (int k = 9; k <= 16; k++) begin
      waitUntil(tStart + k);
      if (k == 10) mode = 1'b0;
      checkOutput("osDoneHold", done, 1);
      checkOutput("osNoTick", baseTick, 0);
    end
    endScenario("oneShot");

    // Pause: enable low for 5 edges mid-interval
    applyStimulus(1'b1, 4'd3, 1'b0);
    tStart = cycle + 1;
    expQ.push_back(tStart + 17);
    expQ.push_back(tStart + 29);
    waitUntil(tStart + 6);
    checkOutput("pauseCountPre", count, 1);
    enable = 1'b0;
    for (int k = 7; k <= 11; k++) begin
      waitUntil(tStart + k);
      checkOutput("pauseCount", count, 1);
      checkOutput("pauseNoTick", baseTick, 0);
      checkOutput("pauseRunning", running, 0);
    end
    enable = 1'b1;
    waitUntil(tStart + 12);
    checkOutput("resumeRunning", running, 1);
    checkOutput("resumeNoTick", baseTick, 0);
    waitUntil(tStart + 13);
    checkOutput("resumeTick", baseTick, 1);
    checkOutput("resumeCount", count, 2);
    waitUntil(tStart + 17);
    checkOutput("pauseWrapCount", count, 0);
    waitUntil(tStart + 29);
    endScenario("pause");

    // restart on the timeout edge suppresses the pulse
    applyStimulus(1'b1, 4'd2, 1'b0);
    tStart = cycle + 1;
    waitUntil(tStart + 7);
    checkOutput("rsCountPre", count, 1);
    restart = 1'b1;
    enable  = 1'b0;
    waitUntil(tStart + 8);
    restart = 1'b0;
    checkOutput("rsTimeout", timeout, 0);
    checkOutput("rsBaseTick", baseTick, 0);
    checkOutput("rsCount", count, 0);
    waitUntil(tStart + 14);
    checkOutput("rsQueue", expQ.size(), 0);

    // period shrinks from 8 to 2 while count is 5
    applyStimulus(1'b1, 4'd8, 1'b0);
    tStart = cycle + 1;
    waitUntil(tStart + 20);
    checkOutput("shrinkCountPre", count, 5);
    period = 4'd2;
    expQ.push_back(tStart + 24);
    expQ.push_back(tStart + 32);
    waitUntil(tStart + 24);
    checkOutput("shrinkCount", count, 0);
    waitUntil(tStart + 28);
    checkOutput("shrinkCountNext", count, 1);
    waitUntil(tStart + 32);
    endScenario("shrink");

    // period driven to 0 while running returns to IDLE
    applyStimulus(1'b1, 4'd3, 1'b0);
    tStart = cycle + 1;
    waitUntil(tStart + 5);
    checkOutput("zeroCountPre", count, 1);
    period = 4'd0;
    waitUntil(tStart + 6);
    checkOutput("zeroRunning", running, 0);
    checkOutput("zeroCount", count, 0);
    waitUntil(tStart + 8);
    checkOutput("zeroIdleRunning", running, 0);
    period = 4'd3;
    tNext = cycle + 1;
    expQ.push_back(tNext + 12);
    waitUntil(tNext);
    checkOutput("zeroRestartRunning", running, 1);
    waitUntil(tNext + 12);
    endScenario("periodZero");

    // Asynchronous reset between edges
    applyStimulus(1'b1, 4'd3, 1'b0);
    tStart = cycle + 1;
    waitUntil(tStart + 8);
    checkOutput("arstTickPre", baseTick, 1);
    checkOutput("arstCountPre", count, 2);
    #2 rst = 1'b0;
    #1;
    checkOutput("arstBaseTick", baseTick, 0);
    checkOutput("arstCount", count, 0);
    checkOutput("arstRunning", running, 0);
    checkOutput("arstTimeout", timeout, 0);
    checkOutput("arstDone", done, 0);
    @(negedge clk);
    checkOutput("arstHoldRunning", running, 0);
    rst = 1'b1;
    tNext = cycle + 1;
    expQ.push_back(tNext + 12);
    waitUntil(tNext + 4);
    checkOutput("arstResumeTick", baseTick, 1);
    checkOutput("arstResumeCount", count, 1);
    waitUntil(tNext + 12);
    endScenario("asyncReset");

`ifdef INTERVAL_TIMER_STICKY_EN
    // Sticky timeout flag
    flagClr = 1'b1;
    @(negedge clk);
    flagClr = 1'b0;
    checkOutput("flagCleared", timeoutFlag, 0);
    applyStimulus(1'b1, 4'd2, 1'b0);
    tStart = cycle + 1;
    expQ.push_back(tStart + 8);
    expQ.push_back(tStart + 16);
    waitUntil(tStart + 7);
    checkOutput("flagBefore", timeoutFlag, 0);
    waitUntil(tStart + 8);
    checkOutput("flagSet", timeoutFlag, 1);
    waitUntil(tStart + 10);
    checkOutput("flagHold", timeoutFlag, 1);
    flagClr = 1'b1;
    waitUntil(tStart + 11);
    flagClr = 1'b0;
    checkOutput("flagClr", timeoutFlag, 0);
    waitUntil(tStart + 15);
    flagClr = 1'b1;
    waitUntil(tStart + 16);
    flagClr = 1'b0;
    checkOutput("flagSetWins", timeoutFlag, 1);
    waitUntil(tStart + 17);
    checkOutput("flagAfterCollision", timeoutFlag, 1);
    endScenario("sticky");
    checkOutput("flagSurvivesRestart", timeoutFlag, 1);
`endif

    checkOutput("finalQueue", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
